// File: rtl/usr_nbit.sv
// Universal N-bit shift register with manual ops and an optional self-timed burst mode (USR_NBIT_BURST_EN).
// Latency: one edge per operation; a burst takes WIDTH edges and start/ops are ignored while busy.
module usr_nbit #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             msb_in,
    input  logic             lsb_in,
    input  logic [WIDTH-1:0] i_par,
    input  logic             start,
    input  logic             start_dir,
    output logic [WIDTH-1:0] a_par,
    output logic             msb_out,
    output logic             lsb_out,
    output logic             busy,
    output logic             done
);

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] man_d;

    always_comb begin
        man_d = a_q;
        if (en) begin
            case (mode)
                3'b001:  man_d = {msb_in, a_q[WIDTH-1:1]};
                3'b010:  man_d = {a_q[WIDTH-2:0], lsb_in};
                3'b011:  man_d = i_par;
                3'b100:  man_d = {a_q[0], a_q[WIDTH-1:1]};
                3'b101:  man_d = {a_q[WIDTH-2:0], a_q[WIDTH-1]};
                3'b110:  man_d = {a_q[WIDTH-1], a_q[WIDTH-1:1]};
                default: man_d = a_q;
            endcase
        end
    end

`ifdef USR_NBIT_BURST_EN
    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q;
    logic             dir_q;
    logic [CW-1:0]    cnt_q;
    logic             done_q;
    logic [WIDTH-1:0] burst_d;

    // Fill bits are taken live each edge, only the direction is latched.
    assign burst_d = dir_q ? {a_q[WIDTH-2:0], lsb_in} : {msb_in, a_q[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            dir_q   <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            a_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= RUN;
                        dir_q   <= start_dir;
                        cnt_q   <= '0;
                    end else begin
                        a_q <= man_d;
                    end
                end
                RUN: begin
                    a_q   <= burst_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = (state_q == RUN);
    assign done = done_q;
`else
    logic unused_burst;
    assign unused_burst = start ^ start_dir;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            a_q <= '0;
        end else begin
            a_q <= man_d;
        end
    end

    assign busy = 1'b0;
    assign done = 1'b0;
`endif

    assign a_par   = a_q;
    assign msb_out = a_q[WIDTH-1];
    assign lsb_out = a_q[0];

endmodule
